program_loader: RTL and testbench
=================================

# program_loader

Writer side of the instruction/data RAM consumed by the fetch-execute core. Receives a framed byte stream over a valid/ready handshake, writes the payload into the core's byte-wide RAM from address 0 and verifies an additive checksum. Holds the core in reset until a frame loads cleanly, replacing the hard-coded RAM init sequence.

## Interface
- RAMSIZE, 64: bytes of target RAM; legal frame lengths are 4..RAMSIZE in multiples of 4 (max 255).
- ADDRW, 8: width of `ram_addr` and `byte_count`.

- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  8  stream byte.
- in_valid  in  1  `in_data` valid.
- in_ready  out  1  loader can accept; a byte transfers on a rising edge with `in_valid && in_ready`.
- ram_we  out  1  one-cycle RAM write strobe.
- ram_addr  out  ADDRW  RAM write address.
- ram_wdata  out  8  RAM write data.
- cpu_reset  out  1  active-high reset to the core; high until load completes.
- done  out  1  frame loaded and verified.
- error  out  1  frame rejected.
- byte_count  out  ADDRW  payload bytes written in current frame.

## Operation
- Frame: sync 0xA5, length L, L payload bytes, checksum C; valid when (sum of payload + C) mod 256 == 0.
- States: WAIT_SYNC, GET_LEN, LOAD, GET_CHK, FILL (macro only), DONE, ERR.
- WAIT_SYNC: accepted bytes other than 0xA5 discarded, no writes; 0xA5 -> GET_LEN.
- GET_LEN: L == 0, L > RAMSIZE or L[1:0] != 0 -> ERR; else latch L, clear address, sum and `byte_count` -> LOAD.
- LOAD: each accepted byte written at current address, address/`byte_count` +1, sum += byte (8-bit wrap); after byte L -> GET_CHK. A payload byte of 0xA5 is data, not sync.
- GET_CHK: checksum good -> FILL or DONE; bad -> ERR. Bytes already written are not undone.
- DONE: `done`=1, `cpu_reset`=0, `in_ready`=0; terminal until reset.
- ERR: `error`=1, `cpu_reset`=1, `in_ready`=1; non-0xA5 bytes discarded; 0xA5 clears `error` -> GET_LEN.
- `in_ready`=1 in WAIT_SYNC, GET_LEN, LOAD, GET_CHK, ERR; 0 in FILL, DONE and while `reset` is low.

## Timing
- Reset values: `ram_we` 0, `ram_addr` 0, `ram_wdata` 0, `cpu_reset` 1, `done` 0, `error` 0, `byte_count` 0, `in_ready` 0; state WAIT_SYNC.
- `in_ready` high in the first cycle after `reset` deasserts.
- `ram_we`/`ram_addr`/`ram_wdata` registered: payload byte accepted at edge k appears with `ram_we`=1 in the cycle after edge k; `ram_we` 0 in all other cycles.
- `in_valid` low cycles stall without side effects; back-to-back bytes give back-to-back writes.
- `done`, `error` and the `cpu_reset` fall all appear in the cycle after the edge that accepts the checksum byte (or after the last FILL write).
- `reset` low mid-frame: all outputs return to reset values immediately, including a pending `ram_we`.

## Configuration
- `LOADER_ZERO_FILL_EN` defined: after a good checksum, enter FILL and write 0x00 to addresses L..RAMSIZE-1, one per cycle, then DONE. L == RAMSIZE skips FILL. `byte_count` stays at L.
- Not defined: no FILL state; good checksum goes directly to DONE and RAM above L is untouched.

## Test plan
- Reset: hold `reset` low with `in_valid`=1 -> every output at reset value, no writes; release -> `in_ready`=1 next cycle.
- Good frame A5 08 02 00 10 00 06 00 01 00 E7 -> 8 writes addr 0..7 with those bytes, `byte_count`=8, then `done`=1, `cpu_reset`=0, `in_ready`=0; with `LOADER_ZERO_FILL_EN`, 56 further writes of 0x00 at 8..63 before `done`.
- Junk then frame: 00 FF 3C A5 04 01 02 03 04 F6 -> no writes for junk, 4 writes addr 0..3, `done`=1.
- Bad length: A5 06 -> `error`=1, no writes; then A5 04 01 02 03 04 F6 -> `error` clears on A5, 4 writes, `done`=1.
- Bad checksum: A5 04 01 02 03 04 00 -> 4 writes, `error`=1, `cpu_reset`=1, `done`=0.
- Stalls and abort: good 8-byte frame with `in_valid` low every other cycle -> same writes as back-to-back; repeat with `reset` low after 3 payload bytes -> outputs reset immediately, `byte_count`=0, no further writes.

Source files
------------

// File: rtl/program_loader.sv
// Framed byte-stream loader: writes payload into the core's byte RAM from address 0,
// verifies an additive checksum and releases cpu_reset. Optional: LOADER_ZERO_FILL_EN.
module program_loader #(
  parameter int RAMSIZE = 64,
  parameter int ADDRW   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ram_we,
  output logic [ADDRW-1:0] ram_addr,
  output logic [7:0]       ram_wdata,
  output logic             cpu_reset,
  output logic             done,
  output logic             error,
  output logic [ADDRW-1:0] byte_count
);

  localparam logic [7:0]       SYNC      = 8'hA5;
  localparam logic [7:0]       LEN_MAX   = 8'(RAMSIZE);
  localparam logic [ADDRW-1:0] ADDR_LAST = ADDRW'(RAMSIZE - 1);

  typedef enum logic [2:0] {
    S_WAIT_SYNC,
    S_GET_LEN,
    S_LOAD,
    S_GET_CHK,
`ifdef LOADER_ZERO_FILL_EN
    S_FILL,
`endif
    S_DONE,
    S_ERR
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       sum_q, sum_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [ADDRW-1:0] count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             ram_we_q, ram_we_d;
  logic [ADDRW-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]       ram_wdata_q, ram_wdata_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             fire;
  logic [7:0]       chk_sum;

  assign fire = in_valid && in_ready_q;

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned (no latches).
    state_d     = state_q;
    len_d       = len_q;
    sum_d       = sum_q;
    addr_d      = addr_q;
    count_d     = count_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    chk_sum     = sum_q + in_data;

    case (state_q)
      S_WAIT_SYNC: if (fire && in_data == SYNC) state_d = S_GET_LEN;
      S_GET_LEN: begin
        if (fire) begin
          if (in_data == 8'd0 || in_data > LEN_MAX || in_data[1:0] != 2'b00) begin
            state_d = S_ERR;
          end else begin
            len_d   = in_data;
            addr_d  = '0;
            sum_d   = 8'd0;
            count_d = '0;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (fire) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = addr_q;
          ram_wdata_d = in_data;
          addr_d      = addr_q + 1'b1;
          count_d     = count_q + 1'b1;
          sum_d       = chk_sum;
          if (count_d == ADDRW'(len_q)) state_d = S_GET_CHK;
        end
      end
      S_GET_CHK: begin
        if (fire) begin
          if (chk_sum == 8'd0) begin
`ifdef LOADER_ZERO_FILL_EN
            state_d = (len_q == LEN_MAX) ? S_DONE : S_FILL;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_ERR;
          end
        end
      end
`ifdef LOADER_ZERO_FILL_EN
      // addr_q already sits at L after the payload; byte_count is left at L.
      S_FILL: begin
        ram_we_d    = 1'b1;
        ram_addr_d  = addr_q;
        ram_wdata_d = 8'h00;
        addr_d      = addr_q + 1'b1;
        if (addr_q == ADDR_LAST) state_d = S_DONE;
      end
`endif
      S_DONE: state_d = S_DONE;
      S_ERR:  if (fire && in_data == SYNC) state_d = S_GET_LEN;
      default: state_d = S_WAIT_SYNC;
    endcase

    // Status outputs are registered from the next state so they change one edge after the cause.
    in_ready_d  = (state_d != S_DONE)
`ifdef LOADER_ZERO_FILL_EN
                  && (state_d != S_FILL)
`endif
                  ;
    done_d      = (state_d == S_DONE);
    error_d     = (state_d == S_ERR);
    cpu_reset_d = (state_d != S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_WAIT_SYNC;
      len_q       <= 8'd0;
      sum_q       <= 8'd0;
      addr_q      <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 8'd0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign error      = error_q;
  assign byte_count = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: reset, good/junk/bad-length/bad-checksum
// frames, stalls and mid-frame reset abort. RAM writes are logged by a monitor.
module tb_program_loader;
  localparam int RAMSIZE = 64;
  localparam int ADDRW   = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             ram_we;
  logic [ADDRW-1:0] ram_addr;
  logic [7:0]       ram_wdata;
  logic             cpu_reset;
  logic             done;
  logic             error;
  logic [ADDRW-1:0] byte_count;

  program_loader #(.RAMSIZE(RAMSIZE), .ADDRW(ADDRW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .cpu_reset(cpu_reset),
    .done(done), .error(error), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [ADDRW-1:0] wr_addr[$];
  logic [7:0]       wr_data[$];
  int               wr_cyc[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      wr_addr.push_back(ram_addr);
      wr_data.push_back(ram_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  // Presents one byte and returns #1 after the edge that accepts it.
  task automatic send(input logic [7:0] b);
    int t = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("send_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input bit stall);
    foreach (bytes[i]) begin
      send(bytes[i]);
      if (stall) idle(1);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    clear_log();
  endtask

  task automatic wait_end();
    int t = 0;
    while (done !== 1'b1 && error !== 1'b1 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
  endtask

  task automatic check_log(input string tag, input logic [7:0] exp[$], input bit filled,
                           input bit contig);
    int n = exp.size();
`ifdef LOADER_ZERO_FILL_EN
    if (filled) n = RAMSIZE;
`endif
    check({tag, "_nwr"}, wr_addr.size(), n);
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      check({tag, "_addr"}, {24'd0, wr_addr[i]}, i);
      check({tag, "_data"}, {24'd0, wr_data[i]}, (i < exp.size()) ? {24'd0, exp[i]} : 32'd0);
      if (contig && i < exp.size()) check({tag, "_b2b"}, wr_cyc[i], wr_cyc[0] + i);
    end
  endtask

  logic [7:0] frame_q[$];
  logic [7:0] pay_q[$];

  initial begin
    // Reset held low with traffic offered.
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
    check("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_byte_count", {24'd0, byte_count}, 32'd0);
    check("rst_no_writes", wr_addr.size(), 0);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Good 8-byte frame, back to back.
    clear_log();
    pay_q   = {8'h02, 8'h00, 8'h10, 8'h00, 8'h06, 8'h00, 8'h01, 8'h00};
    frame_q = {8'hA5, 8'h08, 8'h02, 8'h00, 8'h10, 8'h00, 8'h06, 8'h00, 8'h01, 8'h00, 8'hE7};
    send_frame(frame_q, 1'b0);
`ifndef LOADER_ZERO_FILL_EN
    check("good_done_lat", {31'd0, done}, 32'd1);
    check("good_cpurst_lat", {31'd0, cpu_reset}, 32'd0);
`endif
    wait_end();
    idle(2);
    check("good_done", {31'd0, done}, 32'd1);
    check("good_error", {31'd0, error}, 32'd0);
    check("good_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("good_in_ready", {31'd0, in_ready}, 32'd0);
    check("good_byte_count", {24'd0, byte_count}, 32'd8);
    check_log("good", pay_q, 1'b1, 1'b1);

    // Junk before sync.
    do_reset();
    pay_q   = {8'h01, 8'h02, 8'h03, 8'h04};
    frame_q = {8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF6};
    send_frame(frame_q, 1'b0);
    wait_end();
    idle(2);
    check("junk_done", {31'd0, done}, 32'd1);
    check("junk_byte_count", {24'd0, byte_count}, 32'd4);
    check_log("junk", pay_q, 1'b1, 1'b1);

    // Bad length then recovery via sync.
    do_reset();
    frame_q = {8'hA5, 8'h06};
    send_frame(frame_q, 1'b0);
    idle(2);
    check("blen_error", {31'd0, error}, 32'd1);
    check("blen_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("blen_in_ready", {31'd0, in_ready}, 32'd1);
    check("blen_done", {31'd0, done}, 32'd0);
    check("blen_no_writes", wr_addr.size(), 0);
    send(8'hA5);
    check("blen_err_clear", {31'd0, error}, 32'd0);
    frame_q = {8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF6};
    send_frame(frame_q, 1'b0);
    wait_end();
    idle(2);
    check("blen_rec_done", {31'd0, done}, 32'd1);
    check_log("blen_rec", pay_q, 1'b1, 1'b1);

    // Bad checksum: payload stays written, frame rejected.
    do_reset();
    frame_q = {8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    send_frame(frame_q, 1'b0);
    check("bchk_error_lat", {31'd0, error}, 32'd1);
    idle(3);
    check("bchk_error", {31'd0, error}, 32'd1);
    check("bchk_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("bchk_done", {31'd0, done}, 32'd0);
    check("bchk_in_ready", {31'd0, in_ready}, 32'd1);
    check_log("bchk", pay_q, 1'b0, 1'b1);

    // Good frame with in_valid low every other cycle.
    do_reset();
    pay_q   = {8'h02, 8'h00, 8'h10, 8'h00, 8'h06, 8'h00, 8'h01, 8'h00};
    frame_q = {8'hA5, 8'h08, 8'h02, 8'h00, 8'h10, 8'h00, 8'h06, 8'h00, 8'h01, 8'h00, 8'hE7};
    send_frame(frame_q, 1'b1);
    wait_end();
    idle(2);
    check("stall_done", {31'd0, done}, 32'd1);
    check("stall_byte_count", {24'd0, byte_count}, 32'd8);
    check_log("stall", pay_q, 1'b1, 1'b0);

    // Reset asserted while the third payload write is pending.
    do_reset();
    send(8'hA5);
    send(8'h08);
    send(8'h02);
    send(8'h00);
    send(8'h10);
    check("abort_pending_we", {31'd0, ram_we}, 32'd1);
    check("abort_count3", {24'd0, byte_count}, 32'd3);
    reset = 1'b0;
    #1;
    check("abort_ram_we", {31'd0, ram_we}, 32'd0);
    check("abort_ram_addr", {24'd0, ram_addr}, 32'd0);
    check("abort_ram_wdata", {24'd0, ram_wdata}, 32'd0);
    check("abort_byte_count", {24'd0, byte_count}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    check("abort_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    check("abort_held_nwr", wr_addr.size(), 2);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    idle(4);
    check("abort_after_nwr", wr_addr.size(), 2);
    check("abort_after_count", {24'd0, byte_count}, 32'd0);
    check("abort_after_done", {31'd0, done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
